// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle on operand magnitudes; signs are fixed at the end.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 is_md;
  logic                 signed_op, s1, s2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       mul_sum, div_tmp, div_diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;

  assign is_md = start && (op >= OpMult) && (op <= OpDivu);
  assign busy  = (state_q != StIdle);
  assign stall = busy | (is_md & ~flush);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    signed_op = (op == OpMult) || (op == OpDiv);
    s1        = signed_op & num1[WIDTH-1];
    s2        = signed_op & num2[WIDTH-1];
    mag1      = s1 ? (-num1) : num1;
    mag2      = s2 ? (-num2) : num2;

    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    // Remainder is always below the divisor, so shifted value fits in WIDTH+1 bits.
    div_tmp  = p_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_tmp - {1'b0, mcand_q};

    prod = neg_q ? (-p_q) : p_q;
    quot = p_q[WIDTH-1:0];
    rem  = p_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_md) begin
            is_div_d  = (op == OpDiv) || (op == OpDivu);
            p_d       = {{WIDTH{1'b0}}, (is_div_d ? mag1 : mag2)};
            mcand_d   = is_div_d ? mag2 : mag1;
            neg_d     = s1 ^ s2;
            neg_rem_d = s1;
            div0_d    = (num2 == '0);
            cnt_d     = '0;
            state_d   = StRun;
          end else if (start && op == OpMthi) begin
            hi_d = num1;
          end else if (start && op == OpMtlo) begin
            lo_d = num1;
          end
        end
        StRun: begin
          if (is_div_q) begin
            if (div_diff[WIDTH]) begin
              p_d = {div_tmp[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            end else begin
              p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
            end
          end else begin
            p_d = {mul_sum, p_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          if (is_div_q) begin
            lo_d = div0_q ? '1 : (neg_q ? (-quot) : quot);
            hi_d = neg_rem_q ? (-rem) : rem;
          end else begin
            {hi_d, lo_d} = prod;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      p_q       <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  int nb, nd;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .num1  (num1),
    .num2  (num2),
    .flush (flush),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Issue one op, then watch 40 cycles counting busy/done samples.
  // flush_at / extra_at index the observed cycle where flush or a stray start is driven.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int extra_at,
                        output int nbusy, output int ndone);
    @(negedge clk);
    start = 1'b1; op = o; num1 = a; num2 = b;
    #1 check("stall_on_issue", {63'd0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0; op = OpNone;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 40; i++) begin
      nbusy += int'(busy);
      ndone += int'(done);
      flush = (i == flush_at);
      if (i == extra_at) begin
        start = 1'b1; op = OpMultu; num1 = 32'd3; num2 = 32'd5;
        #1 check("stall_while_busy", {63'd0, stall}, 64'd1);
      end
      @(negedge clk);
      flush = 1'b0; start = 1'b0; op = OpNone;
    end
  endtask

  task automatic write_hl(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = o; num1 = v;
    #1 check("mthilo_no_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; op = OpNone;
  endtask

  initial begin
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_md(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, nb, nd);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("multu_busy_cycles", 64'(nb), 64'd33);
    check("multu_done_cycles", 64'(nd), 64'd1);

    run_md(OpMult, 32'hFFFF_FFFD, 32'd7, -1, -1, nb, nd);
    check("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_busy_cycles", 64'(nb), 64'd33);

    run_md(OpDiv, 32'hFFFF_FFF9, 32'd2, -1, -1, nb, nd);
    check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(OpDivu, 32'd100, 32'd7, -1, -1, nb, nd);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    check("divu_done_cycles", 64'(nd), 64'd1);
    run_md(OpDiv, 32'd5, 32'd0, -1, -1, nb, nd);
    check("div_5_by_0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_md(OpDiv, 32'hFFFF_FFFB, 32'd0, -1, -1, nb, nd);
    check("div_neg5_by_0", {hi, lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_md(OpDivu, 32'h8000_0001, 32'd0, -1, -1, nb, nd);
    check("divu_by_0", {hi, lo}, {32'h8000_0001, 32'hFFFF_FFFF});
    run_md(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, nb, nd);
    check("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
    run_md(OpMult, 32'h8000_0000, 32'h8000_0000, -1, -1, nb, nd);
    check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);

    write_hl(OpMthi, 32'hABCD);
    write_hl(OpMtlo, 32'h1234);
    check("mthi_mtlo", {hi, lo}, {32'hABCD, 32'h1234});
    check("mthilo_no_busy", {62'd0, busy, done}, 64'd0);

    // op=000 with start does nothing.
    @(negedge clk); start = 1'b1; op = OpNone; num1 = 32'hDEAD;
    @(negedge clk); start = 1'b0;
    check("op_none_noeffect", {hi, lo}, {32'hABCD, 32'h1234});
    check("op_none_busy", {63'd0, busy}, 64'd0);

    // start together with flush in idle is dropped.
    @(negedge clk); start = 1'b1; op = OpMult; num1 = 32'd2; num2 = 32'd3; flush = 1'b1;
    #1 check("stall_with_flush", {63'd0, stall}, 64'd0);
    @(negedge clk); start = 1'b0; op = OpNone; flush = 1'b0;
    check("flush_start_ignored", {63'd0, busy}, 64'd0);

    run_md(OpMult, 32'd2, 32'd3, 9, -1, nb, nd);
    check("flush_mid_hilo", {hi, lo}, {32'hABCD, 32'h1234});
    check("flush_mid_busy_cycles", 64'(nb), 64'd10);
    check("flush_mid_no_done", 64'(nd), 64'd0);

    run_md(OpMult, 32'd2, 32'd3, 32, -1, nb, nd);
    check("flush_fix_hilo", {hi, lo}, {32'hABCD, 32'h1234});
    check("flush_fix_no_done", 64'(nd), 64'd0);

    // Stray start while busy must not replace the running op.
    run_md(OpDivu, 32'd100, 32'd7, -1, 5, nb, nd);
    check("start_busy_ignored", {hi, lo}, {32'd2, 32'd14});
    check("start_busy_one_done", 64'(nd), 64'd1);

    // Async reset mid-divide.
    @(negedge clk); start = 1'b1; op = OpDiv; num1 = 32'hFFFF_FFF9; num2 = 32'd2;
    @(negedge clk); start = 1'b0; op = OpNone;
    repeat (5) @(negedge clk);
    check("busy_before_rst", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1 check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", {62'd0, busy, done}, 64'd0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      nd += int'(done) + int'(busy);
      @(negedge clk);
    end
    check("rst_no_resume", 64'(nd), 64'd0);
    check("rst_hilo_stays", {hi, lo}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
